// File: rtl/irq_pkg.sv
// Shared constants for the vectored interrupt controller: default register
// addresses and STAT register field positions.
package irq_pkg;

  localparam logic [31:0] ADDR_MASK_DEF = 32'h0000_0060;
  localparam logic [31:0] ADDR_PEND_DEF = 32'h0000_0064;
  localparam logic [31:0] ADDR_STAT_DEF = 32'h0000_0068;

  localparam int unsigned STAT_ACT_V  = 31;
  localparam int unsigned STAT_IE     = 30;
  localparam int unsigned STAT_ID_LSB = 0;
  localparam int unsigned STAT_ID_W   = 5;

endpackage

// File: rtl/irq_sync_edge.sv
// Two-flop synchroniser for one asynchronous interrupt line followed by a
// previous-value flop; flags a single-cycle rising edge.
module irq_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic arm_i,
  input  logic d_i,
  output logic rise_o
);

  logic s1_q, s2_q, s3_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= d_i;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  // arm_i hides the apparent edge of a line that was already high at reset release
  assign rise_o = s2_q & ~s3_q & arm_i;

endmodule

// File: rtl/irq_controller.sv
// Vectored interrupt controller: N edge-triggered, masked, prioritised sources,
// per-source handler vector, saved PC and global enable, memory-mapped regs.
module irq_controller
  import irq_pkg::*;
#(
  parameter int unsigned N_SRC      = 8,
  parameter logic [31:0] VEC_BASE   = 32'h0000_0100,
  parameter int unsigned VEC_STRIDE = 8,
  parameter logic [31:0] ADDR_MASK  = ADDR_MASK_DEF,
  parameter logic [31:0] ADDR_PEND  = ADDR_PEND_DEF,
  parameter logic [31:0] ADDR_STAT  = ADDR_STAT_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_SRC-1:0] irq_in,
  output logic             int_req,
  input  logic             int_ack,
  output logic [31:0]      vector,
  input  logic             rfe,
  input  logic [31:0]      pc_in,
  output logic [31:0]      epc,
  input  logic [31:0]      bus_addr,
  input  logic [31:0]      bus_wdata,
  input  logic             bus_we,
  input  logic             bus_re,
  output logic [31:0]      bus_rdata,
  output logic             bus_hit
);

  logic [N_SRC-1:0]     pend_q, pend_d;
  logic [N_SRC-1:0]     mask_q, mask_d;
  logic                 ie_q, ie_d;
  logic                 act_v_q, act_v_d;
  logic [STAT_ID_W-1:0] act_id_q, act_id_d;
  logic [31:0]          epc_q, epc_d;
  logic                 int_req_q, int_req_d;
  logic [2:0]           arm_q;

  logic [N_SRC-1:0]     rise;
  logic [N_SRC-1:0]     req_vec;
  logic [N_SRC-1:0]     clr;
  logic [STAT_ID_W-1:0] sel;
  logic                 any;
  logic                 ack_fire;
  logic                 hit_mask, hit_pend, hit_stat;
  logic [31:0]          stat_rd;
  logic                 unused_wdata;

  // Rises are ignored until the synchroniser has flushed the level seen at reset release
  always_ff @(posedge clk) begin
    if (rst) arm_q <= '0;
    else     arm_q <= {arm_q[1:0], 1'b1};
  end

  for (genvar g = 0; g < N_SRC; g++) begin : g_src
    irq_sync_edge u_sync (
      .clk    (clk),
      .rst    (rst),
      .arm_i  (arm_q[2]),
      .d_i    (irq_in[g]),
      .rise_o (rise[g])
    );
  end

  assign req_vec = pend_q & mask_q;

  always_comb begin
    sel = '0;
    any = |req_vec;
    for (int unsigned i = N_SRC; i > 0; i--) begin
      if (req_vec[i-1]) sel = STAT_ID_W'(i - 1);
    end
  end

  assign vector   = VEC_BASE + 32'(sel) * VEC_STRIDE;
  assign ack_fire = int_ack & int_req_q;

  assign hit_mask = (bus_addr == ADDR_MASK);
  assign hit_pend = (bus_addr == ADDR_PEND);
  assign hit_stat = (bus_addr == ADDR_STAT);
  assign bus_hit  = hit_mask | hit_pend | hit_stat;

  always_comb begin
    stat_rd = '0;
    stat_rd[STAT_ACT_V] = act_v_q;
    stat_rd[STAT_IE]    = ie_q;
    stat_rd[STAT_ID_LSB +: STAT_ID_W] = act_id_q;
  end

  always_comb begin
    bus_rdata = '0;
    if (bus_re) begin
      if (hit_mask)      bus_rdata = 32'(mask_q);
      else if (hit_pend) bus_rdata = 32'(pend_q);
      else if (hit_stat) bus_rdata = stat_rd;
    end
  end

  always_comb begin
    clr = '0;
    if (bus_we && hit_pend) clr = clr | bus_wdata[N_SRC-1:0];
    if (ack_fire)           clr = clr | (N_SRC'(1) << sel);

    pend_d    = (pend_q & ~clr) | rise;
    mask_d    = (bus_we && hit_mask) ? bus_wdata[N_SRC-1:0] : mask_q;
    ie_d      = ie_q;
    act_v_d   = act_v_q;
    act_id_d  = act_id_q;
    epc_d     = epc_q;
    int_req_d = ie_q & any & ~int_ack;

    // ack beats rfe, which beats a software write of the enable bit
    if (ack_fire) begin
      ie_d     = 1'b0;
      act_v_d  = 1'b1;
      act_id_d = sel;
      epc_d    = pc_in;
    end else if (rfe) begin
      ie_d    = 1'b1;
      act_v_d = 1'b0;
    end else if (bus_we && hit_stat) begin
      ie_d = bus_wdata[STAT_IE];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pend_q    <= '0;
      mask_q    <= '1;
      ie_q      <= 1'b1;
      act_v_q   <= 1'b0;
      act_id_q  <= '0;
      epc_q     <= '0;
      int_req_q <= 1'b0;
    end else begin
      pend_q    <= pend_d;
      mask_q    <= mask_d;
      ie_q      <= ie_d;
      act_v_q   <= act_v_d;
      act_id_q  <= act_id_d;
      epc_q     <= epc_d;
      int_req_q <= int_req_d;
    end
  end

  assign int_req = int_req_q;
  assign epc     = epc_q;

  assign unused_wdata = ^bus_wdata;

endmodule
